lsu_arbiter: RTL and testbench

LSU_ARBITER -- requirements
Module: lsu_arbiter

---
 rtl/lsu_arb_pkg.sv | 25 ++
 rtl/rr_arbiter_2.sv | 22 ++
 rtl/lsu_arbiter.sv | 153 +++++++++++++++
 tb/tb_lsu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the two-requester LSU arbiter.
package lsu_arb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned F3_W       = 3;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Requester index: 0 = core, 1 = DMA/debug.
    typedef logic req_idx_t;

    typedef struct packed {
        logic            wren;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [F3_W-1:0] funct3;
    } lsu_cmd_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on a tie, the requester not granted last wins.
module rr_arbiter_2
    import lsu_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  req_idx_t   last_i,
    output logic [1:0] gnt_c_o
);

    always_comb begin
        gnt_c_o = 2'b00;
        if (req0_i && req1_i) begin
            gnt_c_o = (last_i == 1'b0) ? 2'b10 : 2'b01;
        end else if (req0_i) begin
            gnt_c_o = 2'b01;
        end else if (req1_i) begin
            gnt_c_o = 2'b10;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates a core and a DMA/debug port onto one LSU command channel,
// one transaction at a time, and routes load data back to its owner.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_m0_req,
    input  logic            i_m0_wren,
    input  logic [XLEN-1:0] i_m0_addr,
    input  logic [XLEN-1:0] i_m0_wdata,
    input  logic [F3_W-1:0] i_m0_funct3,
    output logic            o_m0_gnt,
    output logic            o_m0_rvalid,
    output logic [XLEN-1:0] o_m0_rdata,

    input  logic            i_m1_req,
    input  logic            i_m1_wren,
    input  logic [XLEN-1:0] i_m1_addr,
    input  logic [XLEN-1:0] i_m1_wdata,
    input  logic [F3_W-1:0] i_m1_funct3,
    output logic            o_m1_gnt,
    output logic            o_m1_rvalid,
    output logic [XLEN-1:0] o_m1_rdata,

    output logic [XLEN-1:0] o_lsu_addr,
    output logic [XLEN-1:0] o_st_data,
    output logic            o_lsu_wren,
    output logic [F3_W-1:0] o_funct3,
    input  logic [XLEN-1:0] i_ld_data
);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_idx_t        last_q, last_d;
    req_idx_t        owner_q, owner_d;
    lsu_cmd_t        cmd_q, cmd_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic [XLEN-1:0] rdata0_q, rdata0_d;
    logic [XLEN-1:0] rdata1_q, rdata1_d;

    logic [1:0]      rr_gnt_c;
    logic [1:0]      gnt_c;
    logic            sample_c;
    lsu_cmd_t        m0_cmd_c, m1_cmd_c;

    assign m0_cmd_c = '{wren: i_m0_wren, addr: i_m0_addr, wdata: i_m0_wdata, funct3: i_m0_funct3};
    assign m1_cmd_c = '{wren: i_m1_wren, addr: i_m1_addr, wdata: i_m1_wdata, funct3: i_m1_funct3};

    rr_arbiter_2 u_rr (
        .req0_i  (i_m0_req),
        .req1_i  (i_m1_req),
        .last_i  (last_q),
        .gnt_c_o (rr_gnt_c)
    );

    // Next-state, grant and load-capture logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        rvalid_d = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gnt_c    = 2'b00;
        sample_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_rst && (rr_gnt_c != 2'b00)) begin
                    gnt_c   = rr_gnt_c;
                    owner_d = rr_gnt_c[1];
                    last_d  = rr_gnt_c[1];
                    cmd_d   = rr_gnt_c[1] ? m1_cmd_c : m0_cmd_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_q.wren) begin
                    state_d = IDLE;
                end else if (RD_LAT == 0) begin
                    sample_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    sample_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load data lands in the owner's register; the other port keeps its value.
        if (sample_c) begin
            rvalid_d[owner_q] = 1'b1;
            if (owner_q == 1'b1) begin
                rdata1_d = i_ld_data;
            end else begin
                rdata0_d = i_ld_data;
            end
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cmd_q    <= '0;
            rvalid_q <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cmd_q    <= cmd_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign o_m0_gnt    = gnt_c[0];
    assign o_m1_gnt    = gnt_c[1];
    assign o_m0_rvalid = rvalid_q[0];
    assign o_m1_rvalid = rvalid_q[1];
    assign o_m0_rdata  = rdata0_q;
    assign o_m1_rdata  = rdata1_q;

    assign o_lsu_addr  = cmd_q.addr;
    assign o_st_data   = cmd_q.wdata;
    assign o_funct3    = cmd_q.funct3;
    assign o_lsu_wren  = i_rst && (state_q == ISSUE) && cmd_q.wren;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter: directed scenarios then random traffic
// against a transaction-timeline reference model.
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam int unsigned LAT_A = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_wren, m1_req, m1_wren;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, ld_data;
    logic [2:0]  m0_f3, m1_f3;
    logic        b_m0_req, b_m1_req;

    logic        a_m0_gnt, a_m1_gnt, a_m0_rv, a_m1_rv, a_wren;
    logic [31:0] a_m0_rd, a_m1_rd, a_addr, a_wdata;
    logic [2:0]  a_f3;
    logic        b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv, b_wren;
    logic [31:0] b_m0_rd, b_m1_rd, b_addr, b_wdata;
    logic [2:0]  b_f3;

    lsu_arbiter #(.RD_LAT(LAT_A)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_funct3(m0_f3),
        .o_m0_gnt(a_m0_gnt), .o_m0_rvalid(a_m0_rv), .o_m0_rdata(a_m0_rd),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_funct3(m1_f3),
        .o_m1_gnt(a_m1_gnt), .o_m1_rvalid(a_m1_rv), .o_m1_rdata(a_m1_rd),
        .o_lsu_addr(a_addr), .o_st_data(a_wdata), .o_lsu_wren(a_wren),
        .o_funct3(a_f3), .i_ld_data(ld_data)
    );

    lsu_arbiter #(.RD_LAT(0)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(b_m0_req), .i_m0_wren(m0_wren), .i_m0_addr(m0_addr),
        .i_m0_wdata(m0_wdata), .i_m0_funct3(m0_f3),
        .o_m0_gnt(b_m0_gnt), .o_m0_rvalid(b_m0_rv), .o_m0_rdata(b_m0_rd),
        .i_m1_req(b_m1_req), .i_m1_wren(m1_wren), .i_m1_addr(m1_addr),
        .i_m1_wdata(m1_wdata), .i_m1_funct3(m1_f3),
        .o_m1_gnt(b_m1_gnt), .o_m1_rvalid(b_m1_rv), .o_m1_rdata(b_m1_rd),
        .o_lsu_addr(b_addr), .o_st_data(b_wdata), .o_lsu_wren(b_wren),
        .o_funct3(b_f3), .i_ld_data(ld_data)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester side: pending flag and held command per port.
    bit       pend [2];
    lsu_cmd_t cmd  [2];

    // Reference model: absolute cycle numbers of the in-flight transaction.
    int          idle_at, issue_t, sample_t;
    bit          m_last, m_owner;
    lsu_cmd_t    m_cmd;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_f3;
    logic [1:0]  e_rv;
    logic [31:0] e_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idle_at  = cyc + 1;
        issue_t  = -1;
        sample_t = -1;
        m_last   = 1'b1;
        m_owner  = 1'b0;
        m_cmd    = '0;
        e_addr   = '0;
        e_wdata  = '0;
        e_f3     = '0;
        e_rv     = 2'b00;
        e_rd[0]  = '0;
        e_rd[1]  = '0;
    endtask

    task automatic set_cmd(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f);
        pend[i] = 1'b1;
        cmd[i]  = '{wren: w, addr: a, wdata: d, funct3: f};
    endtask

    task automatic drive();
        m0_req = pend[0]; m0_wren = cmd[0].wren; m0_addr = cmd[0].addr;
        m0_wdata = cmd[0].wdata; m0_f3 = cmd[0].funct3;
        m1_req = pend[1]; m1_wren = cmd[1].wren; m1_addr = cmd[1].addr;
        m1_wdata = cmd[1].wdata; m1_f3 = cmd[1].funct3;
    endtask

    // Compare DUT A against the model for the current cycle, then advance the model.
    task automatic cyc_chk();
        logic [1:0] eg;
        logic       ew;
        drive();
        @(negedge clk);
        eg = 2'b00;
        if (rst && cyc >= idle_at) begin
            if (pend[0] && pend[1]) eg = m_last ? 2'b01 : 2'b10;
            else if (pend[0])       eg = 2'b01;
            else if (pend[1])       eg = 2'b10;
        end
        ew = (rst && cyc == issue_t) ? m_cmd.wren : 1'b0;
        chk("gnt0",   32'(a_m0_gnt), 32'(eg[0]));
        chk("gnt1",   32'(a_m1_gnt), 32'(eg[1]));
        chk("wren",   32'(a_wren),   32'(ew));
        chk("addr",   a_addr,        e_addr);
        chk("wdata",  a_wdata,       e_wdata);
        chk("funct3", 32'(a_f3),     32'(e_f3));
        chk("rv0",    32'(a_m0_rv),  32'(e_rv[0]));
        chk("rv1",    32'(a_m1_rv),  32'(e_rv[1]));
        chk("rd0",    a_m0_rd,       e_rd[0]);
        chk("rd1",    a_m1_rd,       e_rd[1]);
        if (!rst) begin
            model_reset();
        end else begin
            e_rv = 2'b00;
            if (cyc == sample_t) begin
                e_rv[m_owner]  = 1'b1;
                e_rd[m_owner]  = ld_data;
            end
            if (eg != 2'b00) begin
                m_owner = eg[1];
                m_last  = eg[1];
                m_cmd   = cmd[eg[1]];
                pend[eg[1]] = 1'b0;
                issue_t = cyc + 1;
                e_addr  = m_cmd.addr;
                e_wdata = m_cmd.wdata;
                e_f3    = m_cmd.funct3;
                if (m_cmd.wren) begin
                    sample_t = -1;
                    idle_at  = cyc + 2;
                end else begin
                    sample_t = cyc + 1 + LAT_A;
                    idle_at  = cyc + 2 + LAT_A;
                end
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ld_data = '0; b_m0_req = 1'b0; b_m1_req = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0; cmd[0] = '0; cmd[1] = '0;
        drive();
        @(posedge clk);
        #1;
        model_reset();
        idle_at = 0;

        // Reset state.
        cyc_chk();
        chk("rst_wren", 32'(a_wren), 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_b_rv0", 32'(b_m0_rv), 32'd0);
        adv();

        // Tie on the first IDLE cycle: m0 first, m1 two cycles later.
        rst = 1'b1;
        set_cmd(0, 1'b1, 32'h0000_0100, 32'h1111_1111, 3'b010);
        set_cmd(1, 1'b1, 32'h0000_0200, 32'h2222_2222, 3'b001);
        cyc_chk(); chk("tie_m0", 32'(a_m0_gnt), 32'd1); chk("tie_m1_held", 32'(a_m1_gnt), 32'd0); adv();
        cyc_chk(); chk("issue_no_gnt", 32'(a_m1_gnt), 32'd0); adv();
        cyc_chk(); chk("m1_second", 32'(a_m1_gnt), 32'd1); adv();
        cyc_chk(); adv();

        // m0 store: single-cycle wren with the command, no rvalid.
        set_cmd(0, 1'b1, 32'h0000_7010, 32'hDEAD_BEEF, 3'b010);
        cyc_chk(); chk("st_gnt", 32'(a_m0_gnt), 32'd1); adv();
        cyc_chk();
        chk("st_wren", 32'(a_wren), 32'd1);
        chk("st_addr", a_addr, 32'h0000_7010);
        chk("st_data", a_wdata, 32'hDEAD_BEEF);
        chk("st_f3", 32'(a_f3), 32'd2);
        adv();
        cyc_chk();
        chk("st_wren_off", 32'(a_wren), 32'd0);
        chk("st_no_rv", 32'({a_m1_rv, a_m0_rv}), 32'd0);
        chk("st_addr_hold", a_addr, 32'h0000_7010);
        adv();

        // m1 load, RD_LAT=1.
        set_cmd(1, 1'b0, 32'h0000_4000, 32'h0, 3'b100);
        ld_data = $urandom;
        cyc_chk(); chk("ld_gnt", 32'(a_m1_gnt), 32'd1); adv();
        ld_data = $urandom;
        cyc_chk(); chk("ld_wren0", 32'(a_wren), 32'd0); adv();
        ld_data = 32'h1234_5678;
        cyc_chk(); adv();
        ld_data = $urandom;
        cyc_chk();
        chk("ld_rv1", 32'(a_m1_rv), 32'd1);
        chk("ld_rd1", a_m1_rd, 32'h1234_5678);
        chk("ld_rv0", 32'(a_m0_rv), 32'd0);
        adv();
        cyc_chk(); chk("ld_rv1_off", 32'(a_m1_rv), 32'd0); chk("ld_rd1_hold", a_m1_rd, 32'h1234_5678); adv();

        // m0 continuous, m1 once: m0, m1, m0.
        for (int k = 0; k < 6; k++) begin
            if (!pend[0]) set_cmd(0, 1'b1, 32'h100 + 32'(k), 32'($urandom), 3'b000);
            if (k == 0) set_cmd(1, 1'b1, 32'h0000_0900, 32'h9, 3'b001);
            cyc_chk();
            if (k == 0) chk("alt_m0_a", 32'(a_m0_gnt), 32'd1);
            if (k == 2) chk("alt_m1",   32'(a_m1_gnt), 32'd1);
            if (k == 4) chk("alt_m0_b", 32'(a_m0_gnt), 32'd1);
            adv();
        end
        pend[0] = 1'b0;

        // Reset during WAIT abandons the load.
        set_cmd(0, 1'b0, 32'h0000_8000, 32'h0, 3'b010);
        cyc_chk(); adv();
        cyc_chk(); adv();
        rst = 1'b0; ld_data = 32'hAAAA_5555;
        cyc_chk(); adv();
        rst = 1'b1;
        set_cmd(1, 1'b1, 32'h0000_0A00, 32'h0A, 3'b000);
        cyc_chk();
        chk("rstw_idle_gnt", 32'(a_m1_gnt), 32'd1);
        chk("rstw_no_rv", 32'({a_m1_rv, a_m0_rv}), 32'd0);
        chk("rstw_addr0", a_addr, 32'd0);
        chk("rstw_rd1_0", a_m1_rd, 32'd0);
        adv();
        cyc_chk(); adv();

        // RD_LAT=0 load on the second instance.
        cmd[0] = '{wren: 1'b0, addr: 32'h0000_0C00, wdata: 32'h0, funct3: 3'b010};
        b_m0_req = 1'b1;
        cyc_chk(); chk("z_gnt", 32'(b_m0_gnt), 32'd1); adv();
        b_m0_req = 1'b0; ld_data = 32'hCAFE_F00D;
        cyc_chk(); chk("z_wren", 32'(b_wren), 32'd0); chk("z_addr", b_addr, 32'h0000_0C00); adv();
        ld_data = $urandom;
        cyc_chk();
        chk("z_rv0", 32'(b_m0_rv), 32'd1);
        chk("z_rd0", b_m0_rd, 32'hCAFE_F00D);
        chk("z_rv1", 32'(b_m1_rv), 32'd0);
        adv();
        cyc_chk(); chk("z_rv0_off", 32'(b_m0_rv), 32'd0); adv();

        // Random traffic, occasional reset and dropped held-off requests.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)));
                else if (pend[i] && cyc < idle_at && $urandom_range(0, 9) == 0)
                    pend[i] = 1'b0;
            end
            ld_data = $urandom;
            rst = ($urandom_range(0, 99) != 0);
            cyc_chk();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
